// File: rtl/boot_pkg.sv
// Shared types for the boot sequencer: loader mode, FSM state and error codes.
package boot_pkg;

    typedef enum logic [1:0] {
        STALL = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD_S = 3'd2,
        RUN    = 3'd3,
        HALTED = 3'd4,
        ERROR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        E_NONE    = 2'd0,
        E_FRAME   = 2'd1,
        E_TIMEOUT = 2'd2,
        E_OVF     = 2'd3
    } err_t;

    // Loader mode presented while sitting in a given state.
    function automatic mode_t state_mode(input state_t s);
        case (s)
            LOAD_S:  return LOAD;
            RUN:     return EXEC;
            default: return STALL;
        endcase
    endfunction

endpackage

// File: rtl/boot_ctrl_if.sv
// Handshake/status bundle between the host side and the boot sequencer.
interface boot_ctrl_if #(
    parameter int INST_SIZE = 10
);
    logic                 start;
    logic                 rx_ready;
    logic                 ferr;
    logic                 loader_done;
    logic                 cpu_halt;
    logic [1:0]           mode;
    logic                 loader_rstn;
    logic                 cpu_rstn;
    logic                 busy;
    logic                 err;
    logic [1:0]           err_code;
    logic [INST_SIZE:0]   byte_count;
    logic [31:0]          run_cycles;

    modport master (
        output start, rx_ready, ferr, loader_done, cpu_halt,
        input  mode, loader_rstn, cpu_rstn, busy, err, err_code, byte_count, run_cycles
    );

    modport slave (
        input  start, rx_ready, ferr, loader_done, cpu_halt,
        output mode, loader_rstn, cpu_rstn, busy, err, err_code, byte_count, run_cycles
    );
endinterface

// File: rtl/boot_ctrl_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Clear wins over enable; the count never wraps past all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/boot_ctrl.sv
// Boot sequencer: clears the loader, streams the program in, then runs the CPU.
// All outputs are flops loaded from the next state on the same edge as the state.
//
//  state  | meaning
//  IDLE   | after reset, waiting for start
//  CLEAR  | loader held in reset for CLR_CYCLES cycles, counters cleared
//  LOAD_S | loader accepting UART bytes, watching for done/errors
//  RUN    | CPU released and executing
//  HALTED | CPU stopped at halt, state kept for inspection
//  ERROR  | load failed, err_code/byte_count held until start
module boot_ctrl
    import boot_pkg::*;
#(
    parameter int INST_SIZE      = 10,
    parameter int TIMEOUT_CYCLES = 10_000_000,
    parameter int CLR_CYCLES     = 2
) (
    input  logic      clk,
    input  logic      rstn,
    boot_ctrl_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int CW = $clog2(CLR_CYCLES) + 1;
    localparam logic [TW-1:0]      T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]      C_LAST = CW'(CLR_CYCLES - 1);
    localparam logic [INST_SIZE:0] CAP    = {1'b1, {INST_SIZE{1'b0}}};

    state_t              state;
    state_t              next_state;
    err_t                err_cause;
    logic [CW-1:0]       clr_cnt;
    logic [TW-1:0]       idle_cnt;
    logic [INST_SIZE:0]  byte_cnt;
    logic [31:0]         run_cnt;

    mode_t               mode_q;
    mode_t               mode_d;
    logic                loader_rstn_q;
    logic                loader_rstn_d;
    logic                cpu_rstn_q;
    logic                cpu_rstn_d;
    logic                busy_q;
    logic                busy_d;
    logic                err_q;
    logic                err_d;
    err_t                err_code_q;
    err_t                err_code_d;

    logic                cnt_clr;
    logic                byte_en;
    logic                idle_clr;
    logic                idle_en;
    logic                run_en;

    // State, output flops and the CLEAR hold down-counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            clr_cnt       <= '0;
            mode_q        <= STALL;
            loader_rstn_q <= 1'b0;
            cpu_rstn_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= E_NONE;
        end else begin
            state         <= next_state;
            mode_q        <= mode_d;
            loader_rstn_q <= loader_rstn_d;
            cpu_rstn_q    <= cpu_rstn_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            if (next_state == CLEAR && state != CLEAR) begin
                clr_cnt <= C_LAST;
            end else if (state == CLEAR && clr_cnt != '0) begin
                clr_cnt <= clr_cnt - CW'(1);
            end
        end
    end

    // Transition logic; in LOAD, done beats frame error beats overflow beats timeout.
    always_comb begin
        next_state = state;
        err_cause  = E_NONE;
        unique case (state)
            IDLE: begin
                if (bus.start) next_state = CLEAR;
            end
            CLEAR: begin
                if (clr_cnt == '0) next_state = LOAD_S;
            end
            LOAD_S: begin
                if (bus.loader_done) begin
                    next_state = RUN;
                end else if (bus.rx_ready && bus.ferr) begin
                    next_state = ERROR;
                    err_cause  = E_FRAME;
                end else if (byte_cnt == CAP) begin
                    next_state = ERROR;
                    err_cause  = E_OVF;
                end else if (byte_cnt != '0 && idle_cnt == T_LAST) begin
                    next_state = ERROR;
                    err_cause  = E_TIMEOUT;
                end
            end
            RUN: begin
                if (bus.cpu_halt)   next_state = HALTED;
                else if (bus.start) next_state = CLEAR;
            end
            HALTED, ERROR: begin
                if (bus.start) next_state = CLEAR;
            end
            default: next_state = IDLE;
        endcase
    end

    // Next output values, derived from the state being entered.
    always_comb begin
        mode_d        = state_mode(next_state);
        loader_rstn_d = 1'b1;
        cpu_rstn_d    = 1'b0;
        busy_d        = 1'b0;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
        unique case (next_state)
            IDLE:    loader_rstn_d = 1'b0;
            CLEAR: begin
                loader_rstn_d = 1'b0;
                busy_d        = 1'b1;
                err_code_d    = E_NONE;
            end
            LOAD_S:  busy_d     = 1'b1;
            RUN:     cpu_rstn_d = 1'b1;
            HALTED:  cpu_rstn_d = 1'b1;
            ERROR: begin
                err_d = 1'b1;
                if (state != ERROR) err_code_d = err_cause;
            end
            default: loader_rstn_d = 1'b0;
        endcase
    end

    // Counter controls; byte_count is frozen once capacity is reached.
    always_comb begin
        cnt_clr  = (next_state == CLEAR);
        byte_en  = (state == LOAD_S) && bus.rx_ready && (byte_cnt != CAP);
        idle_clr = cnt_clr || ((state == LOAD_S) && bus.rx_ready);
        idle_en  = (state == LOAD_S);
        run_en   = (state == RUN);
    end

    sat_counter #(.WIDTH(TW)) u_idle_timer (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (idle_clr),
        .en    (idle_en),
        .count (idle_cnt)
    );

    sat_counter #(.WIDTH(INST_SIZE + 1)) u_byte_count (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (cnt_clr),
        .en    (byte_en),
        .count (byte_cnt)
    );

    sat_counter #(.WIDTH(32)) u_run_cycles (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (cnt_clr),
        .en    (run_en),
        .count (run_cnt)
    );

    assign bus.mode        = mode_q;
    assign bus.loader_rstn = loader_rstn_q;
    assign bus.cpu_rstn    = cpu_rstn_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
    assign bus.err_code    = err_code_q;
    assign bus.byte_count  = byte_cnt;
    assign bus.run_cycles  = run_cnt;

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl with a scoreboard of expected output snapshots.
module tb_boot_ctrl;

    localparam int IS = 4;

    localparam int S_IDLE   = 0;
    localparam int S_CLEAR  = 1;
    localparam int S_LOAD   = 2;
    localparam int S_RUN    = 3;
    localparam int S_HALTED = 4;
    localparam int S_ERROR  = 5;

    typedef struct {
        string       tag;
        logic [1:0]  mode;
        logic        lr;
        logic        cr;
        logic        busy;
        logic        err;
        logic [1:0]  ec;
        logic [IS:0] bc;
        logic [31:0] rc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    exp_t sb[$];
    int   n_run = 0;
    int   n_fail = 0;

    boot_ctrl_if #(.INST_SIZE(IS)) bus ();

    boot_ctrl #(
        .INST_SIZE      (IS),
        .TIMEOUT_CYCLES (50),
        .CLR_CYCLES     (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic expect_st(input string tag, input int st, input int ec, input int bc, input int rc);
        exp_t e;
        e.tag = tag;
        e.ec  = 2'(ec);
        e.bc  = (IS + 1)'(bc);
        e.rc  = 32'(rc);
        case (st)
            S_CLEAR:  begin e.mode = 2'd0; e.lr = 1'b0; e.cr = 1'b0; e.busy = 1'b1; e.err = 1'b0; end
            S_LOAD:   begin e.mode = 2'd1; e.lr = 1'b1; e.cr = 1'b0; e.busy = 1'b1; e.err = 1'b0; end
            S_RUN:    begin e.mode = 2'd2; e.lr = 1'b1; e.cr = 1'b1; e.busy = 1'b0; e.err = 1'b0; end
            S_HALTED: begin e.mode = 2'd0; e.lr = 1'b1; e.cr = 1'b1; e.busy = 1'b0; e.err = 1'b0; end
            S_ERROR:  begin e.mode = 2'd0; e.lr = 1'b1; e.cr = 1'b0; e.busy = 1'b0; e.err = 1'b1; end
            default:  begin e.mode = 2'd0; e.lr = 1'b0; e.cr = 1'b0; e.busy = 1'b0; e.err = 1'b0; end
        endcase
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_run++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "mode",        32'(bus.mode),        32'(e.mode));
        cmp(e.tag, "loader_rstn", 32'(bus.loader_rstn), 32'(e.lr));
        cmp(e.tag, "cpu_rstn",    32'(bus.cpu_rstn),    32'(e.cr));
        cmp(e.tag, "busy",        32'(bus.busy),        32'(e.busy));
        cmp(e.tag, "err",         32'(bus.err),         32'(e.err));
        cmp(e.tag, "err_code",    32'(bus.err_code),    32'(e.ec));
        cmp(e.tag, "byte_count",  32'(bus.byte_count),  32'(e.bc));
        cmp(e.tag, "run_cycles",  bus.run_cycles,       e.rc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string tag, input int st, input int ec, input int bc, input int rc);
        expect_st(tag, st, ec, bc, rc);
        step();
        check_out();
    endtask

    task automatic restart(input string tag);
        bus.start = 1'b1;
        cycle({tag, "_clr0"}, S_CLEAR, 0, 0, 0);
        bus.start = 1'b0;
        cycle({tag, "_clr1"}, S_CLEAR, 0, 0, 0);
        cycle({tag, "_load"}, S_LOAD, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start       = 1'b0;
        bus.rx_ready    = 1'b0;
        bus.ferr        = 1'b0;
        bus.loader_done = 1'b0;
        bus.cpu_halt    = 1'b0;

        #3;
        expect_st("reset", S_IDLE, 0, 0, 0);
        check_out();
        #9 rstn = 1'b1;
        cycle("idle_hold", S_IDLE, 0, 0, 0);

        // CLEAR lasts two cycles, then LOAD
        restart("t1");

        // eight bytes, done, run 100 cycles, halt
        bus.rx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) cycle("t2_byte", S_LOAD, 0, i, 0);
        bus.rx_ready = 1'b0;
        bus.loader_done = 1'b1;
        cycle("t2_run", S_RUN, 0, 8, 0);
        bus.loader_done = 1'b0;
        repeat (99) step();
        bus.cpu_halt = 1'b1;
        cycle("t2_halt", S_HALTED, 0, 8, 100);
        cycle("t2_frozen", S_HALTED, 0, 8, 100);
        bus.cpu_halt = 1'b0;

        // frame error on the third byte
        restart("t3");
        bus.rx_ready = 1'b1;
        cycle("t3_b1", S_LOAD, 0, 1, 0);
        cycle("t3_b2", S_LOAD, 0, 2, 0);
        bus.ferr = 1'b1;
        cycle("t3_ferr", S_ERROR, 1, 3, 0);
        bus.rx_ready = 1'b0;
        bus.ferr = 1'b0;
        cycle("t3_hold", S_ERROR, 1, 3, 0);
        restart("t3r");

        // start ignored in LOAD; timeout 50 cycles after a lone byte
        bus.start = 1'b1;
        cycle("t4_start_ign", S_LOAD, 0, 0, 0);
        bus.start = 1'b0;
        bus.rx_ready = 1'b1;
        cycle("t4_byte", S_LOAD, 0, 1, 0);
        bus.rx_ready = 1'b0;
        repeat (48) step();
        cycle("t4_pre_to", S_LOAD, 0, 1, 0);
        cycle("t4_timeout", S_ERROR, 2, 1, 0);
        restart("t4r");
        repeat (1000) step();
        cycle("t4_no_bytes", S_LOAD, 0, 0, 0);

        // fill capacity without terminator; extra byte at full is not counted
        bus.rx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) cycle("t5_byte", S_LOAD, 0, i, 0);
        cycle("t5_ovf", S_ERROR, 3, 16, 0);
        bus.rx_ready = 1'b0;
        cycle("t5_ovf_hold", S_ERROR, 3, 16, 0);

        // done wins over frame error; halt wins over start
        restart("t5r");
        bus.rx_ready = 1'b1;
        bus.ferr = 1'b1;
        bus.loader_done = 1'b1;
        cycle("t5_done_ferr", S_RUN, 0, 1, 0);
        bus.rx_ready = 1'b0;
        bus.ferr = 1'b0;
        bus.loader_done = 1'b0;
        cycle("t5_run1", S_RUN, 0, 1, 1);
        bus.cpu_halt = 1'b1;
        bus.start = 1'b1;
        cycle("t5_halt_start", S_HALTED, 0, 1, 2);
        bus.cpu_halt = 1'b0;
        cycle("t5_halted_start", S_CLEAR, 0, 0, 0);
        bus.start = 1'b0;
        cycle("t6_clr1", S_CLEAR, 0, 0, 0);
        cycle("t6_load", S_LOAD, 0, 0, 0);

        // start in RUN drops cpu_rstn on the same edge
        bus.loader_done = 1'b1;
        cycle("t6_run", S_RUN, 0, 0, 0);
        bus.loader_done = 1'b0;
        cycle("t6_run1", S_RUN, 0, 0, 1);
        bus.start = 1'b1;
        cycle("t6_run_start", S_CLEAR, 0, 0, 0);
        bus.start = 1'b0;
        cycle("t6_clr1", S_CLEAR, 0, 0, 0);
        cycle("t6_load2", S_LOAD, 0, 0, 0);
        bus.rx_ready = 1'b1;
        cycle("t6_byte", S_LOAD, 0, 1, 0);
        bus.rx_ready = 1'b0;
        cycle("t6_wait", S_LOAD, 0, 1, 0);

        // async reset mid-LOAD
        rstn = 1'b0;
        #1;
        expect_st("t6_async_rst", S_IDLE, 0, 0, 0);
        check_out();
        #1 rstn = 1'b1;
        cycle("t6_post_rst", S_IDLE, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
